// File: rtl/ved_mac_8x8_if.sv
// Operand/result handshake bundle for the ved_mac_8x8 multiply-accumulate stage.
// master drives operands and result acceptance; slave is the MAC itself.
interface ved_mac_8x8_if #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [LEN_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf
    );
endinterface

// File: rtl/ved_mac_8x8.sv
// Streaming multiply-accumulate around a combinational Vedic 8x8 multiplier.
// Optional macro VED_MAC_SAT_EN: saturate the accumulator instead of wrapping.

module ved_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic c;
    assign c    = (a[1] & b[0]) & (a[0] & b[1]);
    assign p[0] = a[0] & b[0];
    assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign p[2] = (a[1] & b[1]) ^ c;
    assign p[3] = (a[1] & b[1]) & c;
endmodule

module ved_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q  [4];
    logic [7:0] pp [4];

    // Sub-product gi uses a-half gi%2 and b-half gi/2, weighted by both halves.
    for (genvar gi = 0; gi < 4; gi++) begin : g_sub
        ved_2x2 u_m (
            .a (a[2*(gi%2) +: 2]),
            .b (b[2*(gi/2) +: 2]),
            .p (q[gi])
        );
        assign pp[gi] = 8'(q[gi]) << (2 * ((gi % 2) + (gi / 2)));
    end

    assign p = pp[0] + pp[1] + pp[2] + pp[3];
endmodule

module ved_8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [7:0]  q  [4];
    logic [15:0] pp [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_sub
        ved_4x4 u_m (
            .a (a[4*(gi%2) +: 4]),
            .b (b[4*(gi/2) +: 4]),
            .p (q[gi])
        );
        assign pp[gi] = 16'(q[gi]) << (4 * ((gi % 2) + (gi / 2)));
    end

    assign p = pp[0] + pp[1] + pp[2] + pp[3];
endmodule

module ved_mac_8x8 #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    ved_mac_8x8_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_reg, state_next;
    logic             s1_valid_reg, s1_last_reg;
    logic [7:0]       s1_a_reg, s1_b_reg;
    logic [15:0]      prod;
    logic             s2_valid_reg, s2_last_reg;
    logic [15:0]      s2_prod_reg;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [LEN_W-1:0] count_reg;
    logic             ovf_reg;
    logic [ACC_W:0]   sum_full;
    logic             carry;
    logic             accept;
    logic             in_ready_next;
    logic             out_valid_next;

    ved_8x8 u_mul (
        .a (s1_a_reg),
        .b (s1_b_reg),
        .p (prod)
    );

    assign accept   = bus.in_valid && in_ready_next;
    assign sum_full = {1'b0, acc_reg} + {{(ACC_W-15){1'b0}}, s2_prod_reg};
    assign carry    = sum_full[ACC_W];

`ifdef VED_MAC_SAT_EN
    assign acc_next = carry ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    assign acc_next = sum_full[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        in_ready_next  = 1'b0;
        out_valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready_next = rst_n;
                if (accept) begin
                    state_next = bus.in_last ? DRAIN : RUN;
                end
            end
            RUN: begin
                in_ready_next = rst_n;
                if (accept && bus.in_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (s2_valid_reg && s2_last_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_next = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            s2_prod_reg  <= '0;
            acc_reg      <= '0;
            count_reg    <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_a_reg    <= bus.in_a;
                s1_b_reg    <= bus.in_b;
                s1_last_reg <= bus.in_last;
            end
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_prod_reg <= prod;
                s2_last_reg <= s1_last_reg;
            end
            // Result consumed: start the next frame from a clean accumulator.
            if (state_reg == DONE && bus.out_ready) begin
                acc_reg   <= '0;
                count_reg <= '0;
                ovf_reg   <= 1'b0;
            end else begin
                if (s2_valid_reg) begin
                    acc_reg <= acc_next;
                    ovf_reg <= ovf_reg | carry;
                end
                if (accept && !(&count_reg)) begin
                    count_reg <= count_reg + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_next;
    assign bus.out_valid = out_valid_next;
    assign bus.out_acc   = acc_reg;
    assign bus.out_count = count_reg;
    assign bus.out_ovf   = ovf_reg;
endmodule

// File: doc/ved_mac_8x8.md
# ved_mac_8x8

Streaming multiply-accumulate stage built around the combinational `ved_8x8` Vedic multiplier. It sits directly downstream of `ved_8x8` and consumes its 16-bit product. It also sits upstream of it, registering the operands it feeds in. The block accepts a frame of 8-bit operand pairs over a valid/ready handshake and sums the products into a wide accumulator. It presents the frame result with a beat count and an overflow flag on an output valid/ready handshake.

## Interface
- `ACC_W`, default 24: accumulator/result width. Legal range is `ACC_W` >= 16.
- `LEN_W`, default 8: beat-counter width.

- `clk`, in, 1: clock. All logic is on the rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `in_valid`, in, 1: operand pair valid.
- `in_ready`, out, 1: block can accept an operand pair.
- `in_a`, in, 8: multiplicand (unsigned).
- `in_b`, in, 8: multiplier (unsigned).
- `in_last`, in, 1: marks the final pair of the frame.
- `out_valid`, out, 1: frame result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_acc`, out, `ACC_W`: sum of the frame's products.
- `out_count`, out, `LEN_W`: number of pairs in the frame.
- `out_ovf`, out, 1: the accumulator exceeded 2^`ACC_W`-1 during the frame.

## Operation
- A beat is accepted on an edge where `in_valid && in_ready`.
- Pipeline:
  - S1 registers `in_a`/`in_b`/`in_last` with a valid bit.
  - One `ved_8x8` instance multiplies the S1 operands.
  - S2 registers the product, last flag and valid bit.
  - S3 adds the S2 product into `acc` when the S2 valid bit is set.
- FSM states and transitions:
  - IDLE → RUN on the first accepted beat.
  - RUN or IDLE → DRAIN on an accepted beat with `in_last`=1. A single-beat frame goes IDLE→DRAIN directly.
  - DRAIN → DONE when the S2 last beat is accumulated.
  - DONE → IDLE on `out_valid && out_ready`.
- `in_ready` = `rst_n` && (state is IDLE or RUN). It is deasserted in DRAIN and DONE, so only one frame is in flight.
- `out_valid` = 1 only in DONE. `out_acc`, `out_count` and `out_ovf` are held stable while `out_valid`=1 and `out_ready`=0.
- Leaving DONE clears `acc`, `count` and `ovf` to 0 on the same edge.
- `count` increments per accepted beat and saturates at 2^`LEN_W`-1.
- Arithmetic: the product is zero-extended to `ACC_W`, then added to `acc`. Without saturation, the sum wraps modulo 2^`ACC_W`.
- `ovf` is sticky within a frame. It is set on any carry out of bit `ACC_W`-1.
- Bubbles (`in_valid`=0 mid-frame) propagate as invalid stages and leave `acc` unchanged.
- Reset (`rst_n`=0 at an edge), at any time including mid-frame:
  - state = IDLE.
  - All pipeline valid bits = 0.
  - `acc` = `count` = `ovf` = 0.
  - `out_valid` = 0.
  - `in_ready` = 0 while `rst_n`=0, and 1 from the first cycle after release.
  - Any partial frame is discarded.
- Reset values: `out_valid` 0, `out_acc` 0, `out_count` 0, `out_ovf` 0, `in_ready` 0.

## Timing
- Last beat accepted at edge k:
  - S1 is loaded at k and S2 at k+1.
  - `acc` is final at k+2, and state = DONE after k+2.
  - `out_valid` is first high in the cycle after edge k+2, so latency is 2 edges.
- `in_ready` falls in the cycle after edge k, because it is driven from registered state.
- Result handshake completes at edge m: `in_ready` = 1 and `out_valid` = 0 in the cycle after m.
- Minimum frame-to-frame gap is 3 cycles from last accept to the next accept, with `out_ready` tied high.
- No combinational path from `in_valid` or `out_ready` to any output.

## Configuration
- `VED_MAC_SAT_EN` defined: the accumulator saturates.
  - A sum exceeding 2^`ACC_W`-1 loads all-ones and sets `ovf`.
  - `acc` then stays at all-ones for the rest of the frame.
- `VED_MAC_SAT_EN` undefined: the accumulator wraps modulo 2^`ACC_W` and sets `ovf`.

## Test plan
- Basic frame, default params: frame (5,6), (6,7), (9,7,last) → `out_acc`=135, `out_count`=3, `out_ovf`=0. `out_valid` rises in the cycle after edge k+2.
- Single beat: single beat (255,255,last) → `out_acc`=65025, `out_count`=1. The FSM goes IDLE→DRAIN→DONE.
- Overflow, `ACC_W`=16: frame (255,255), (255,255,last).
  - Without macro: `out_acc`=64514, `out_ovf`=1.
  - With `VED_MAC_SAT_EN`: `out_acc`=65535, `out_ovf`=1.
- Output backpressure:
  - Hold `out_ready`=0 for 10 cycles in DONE → outputs stable and `in_ready`=0 throughout.
  - Then pulse `out_ready` → next cycle `in_ready`=1.
  - Next frame (15,15,last) → `out_acc`=225, so there is no carry-over from the previous frame.
- Input bubbles: frame (30,30), 3 idle cycles, (25,25,last) → `out_acc`=1525, `out_count`=2.
- Reset mid-frame: accept (255,250), (255,254), then drive `rst_n`=0 for 2 cycles.
  - During reset: `out_valid`=0, `in_ready`=0.
  - After release, frame (5,6,last) → `out_acc`=30, `out_count`=1, `out_ovf`=0.
